fft_8p_loader: RTL

FFT_8P_LOADER -- requirements
Module: fft_8p_loader

---
 rtl/fft_8p_loader_pkg.sv | 29 ++
 rtl/fft_8p_loader_if.sv | 30 +++
 rtl/fft_8p_loader_bank.sv | 40 ++++
 rtl/fft_8p_loader.sv | 119 +++++++++++
 4 files changed

// File: rtl/fft_8p_loader_pkg.sv
// Shared types and helpers for the FFT frame loader.
package fft_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int N_DEF          = 8;

    // One complex sample at the default width.
    typedef struct packed {
        logic signed [DATA_WIDTH_DEF-1:0] re;
        logic signed [DATA_WIDTH_DEF-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    // Reverse the low 'bits' bits of k.
    function automatic int unsigned bitrev(input int unsigned k, input int unsigned bits);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < bits; i++) begin
            r[bits-1-i] = k[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_8p_loader_if.sv
// Sample stream in, whole frame out, plus the framing error pulse.
interface fft_8p_loader_if
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int N          = N_DEF
);
    logic                               s_valid;
    logic                               s_ready;
    logic signed [DATA_WIDTH-1:0]       s_real;
    logic signed [DATA_WIDTH-1:0]       s_imag;
    logic                               s_last;
    logic                               f_valid;
    logic                               f_ready;
    logic [N-1:0][DATA_WIDTH-1:0]       f_real;
    logic [N-1:0][DATA_WIDTH-1:0]       f_imag;
    logic                               frame_err;

    // Sample source and frame consumer side.
    modport master (
        output s_valid, s_real, s_imag, s_last, f_ready,
        input  s_ready, f_valid, f_real, f_imag, frame_err
    );

    // Loader side.
    modport slave (
        input  s_valid, s_real, s_imag, s_last, f_ready,
        output s_ready, f_valid, f_real, f_imag, frame_err
    );
endinterface

// File: rtl/fft_8p_loader_bank.sv
// One N-entry sample bank: single indexed write port, all slots readable in parallel.
module fft_frame_bank
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int N          = N_DEF,
    localparam int KW        = $clog2(N)
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [KW-1:0]                 wr_addr,
    input  logic signed [DATA_WIDTH-1:0]  wr_real,
    input  logic signed [DATA_WIDTH-1:0]  wr_imag,
    output logic [N-1:0][DATA_WIDTH-1:0]  rd_real,
    output logic [N-1:0][DATA_WIDTH-1:0]  rd_imag
);

    logic [N-1:0][DATA_WIDTH-1:0] mem_real_q, mem_real_d;
    logic [N-1:0][DATA_WIDTH-1:0] mem_imag_q, mem_imag_d;

    // Next storage contents: only the addressed slot changes on a write.
    always_comb begin
        mem_real_d = mem_real_q;
        mem_imag_d = mem_imag_q;
        if (wr_en) begin
            mem_real_d[wr_addr] = wr_real;
            mem_imag_d[wr_addr] = wr_imag;
        end
    end

    // Storage needs no reset; contents are only looked at once a bank is FULL.
    always_ff @(posedge clk) begin
        mem_real_q <= mem_real_d;
        mem_imag_q <= mem_imag_d;
    end

    assign rd_real = mem_real_q;
    assign rd_imag = mem_imag_q;

endmodule

// File: rtl/fft_8p_loader.sv
// Ping-pong frame loader: collects N samples per bank (optionally bit-reversed)
// and presents each completed bank as one parallel frame.
//
//   state        | meaning
//   BANK_EMPTY   | no samples held, free for the writer
//   BANK_FILLING | writer has stored at least one sample of a frame
//   BANK_FULL    | complete frame waiting for (or shown to) the consumer
module fft_8p_loader
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int N          = N_DEF,
    parameter int BITREV     = 1
) (
    input  logic            clk,
    input  logic            rst,
    fft_8p_loader_if.slave  bus
);

    localparam int unsigned KW     = $clog2(N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    bank_state_e   bank_st_q [2];
    bank_state_e   bank_st_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [KW-1:0] k_q, k_d;
    logic          err_q, err_d;

    logic          accept;
    logic          consume;
    logic [KW-1:0] wr_addr;

    logic [N-1:0][DATA_WIDTH-1:0] bank0_real, bank0_imag;
    logic [N-1:0][DATA_WIDTH-1:0] bank1_real, bank1_imag;

    assign bus.s_ready  = (bank_st_q[wr_ptr_q] != BANK_FULL);
    assign bus.f_valid  = (bank_st_q[rd_ptr_q] == BANK_FULL);
    assign bus.f_real   = rd_ptr_q ? bank1_real : bank0_real;
    assign bus.f_imag   = rd_ptr_q ? bank1_imag : bank0_imag;
    assign bus.frame_err = err_q;

    assign accept  = bus.s_valid && bus.s_ready;
    assign consume = bus.f_valid && bus.f_ready;

    // Write and read banks never coincide while both handshake, so the two
    // updates below touch different banks and can both take effect.
    assign wr_addr = (BITREV != 0) ? KW'(bitrev(32'(k_q), KW)) : k_q;

    // Bank states, pointers, sample index and framing error for the next cycle.
    always_comb begin
        bank_st_d = bank_st_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        k_d       = k_q;
        err_d     = 1'b0;

        if (consume) begin
            bank_st_d[rd_ptr_q] = BANK_EMPTY;
            rd_ptr_d            = ~rd_ptr_q;
        end

        if (accept) begin
            if (k_q == K_LAST) begin
                // Frame is complete even when s_last is missing; that only flags an error.
                bank_st_d[wr_ptr_q] = BANK_FULL;
                k_d                 = '0;
                wr_ptr_d            = ~wr_ptr_q;
                err_d               = ~bus.s_last;
            end else if (bus.s_last) begin
                // Early end: drop the partial frame and restart at slot index 0.
                k_d   = '0;
                err_d = 1'b1;
            end else begin
                k_d                 = k_q + 1'b1;
                bank_st_d[wr_ptr_q] = BANK_FILLING;
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_st_q[0] <= BANK_EMPTY;
            bank_st_q[1] <= BANK_EMPTY;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            k_q          <= '0;
            err_q        <= 1'b0;
        end else begin
            bank_st_q <= bank_st_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            k_q       <= k_d;
            err_q     <= err_d;
        end
    end

    fft_frame_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N)) u_bank0 (
        .clk     (clk),
        .wr_en   (accept && !wr_ptr_q),
        .wr_addr (wr_addr),
        .wr_real (bus.s_real),
        .wr_imag (bus.s_imag),
        .rd_real (bank0_real),
        .rd_imag (bank0_imag)
    );

    fft_frame_bank #(.DATA_WIDTH(DATA_WIDTH), .N(N)) u_bank1 (
        .clk     (clk),
        .wr_en   (accept && wr_ptr_q),
        .wr_addr (wr_addr),
        .wr_real (bus.s_real),
        .wr_imag (bus.s_imag),
        .rd_real (bank1_real),
        .rd_imag (bank1_imag)
    );

endmodule
